// File: rtl/bambu_ext_mem_responder.sv
// bambu_ext_mem_responder
// Byte-addressed little-endian memory answering the master-side RAM
// interface of a Bambu `main` top. Each channel answers requests with a
// fixed read/write latency. A preload/peek port lets a bench initialise
// and inspect the contents.
// Optional macro BAMBU_MEM_RESP_ERR_CHECK_EN: enables sticky protocol error
// detection (bad size, oe+we together, out-of-range bytes). When it is not
// defined, err is tied low and byte addresses wrap modulo MEM_BYTES.
module bambu_ext_mem_responder #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SIZE_W      = 5,
  parameter int unsigned MEM_BYTES   = 128,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          M_oe_ram,
  input  logic [N_CH-1:0]          M_we_ram,
  input  logic [N_CH*ADDR_W-1:0]   M_addr_ram,
  input  logic [N_CH*DATA_W-1:0]   M_Wdata_ram,
  input  logic [N_CH*SIZE_W-1:0]   M_data_ram_size,
  output logic [N_CH*DATA_W-1:0]   M_Rdata_ram,
  output logic [N_CH-1:0]          M_DataRdy,
  input  logic                     pl_we,
  input  logic [ADDR_W-1:0]        pl_addr,
  input  logic [7:0]               pl_wdata,
  output logic [7:0]               pl_rdata,
  output logic                     err
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned MAX_DLY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int unsigned CNT_W   = (MAX_DLY < 2) ? 1 : $clog2(MAX_DLY);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  function automatic int unsigned nbytes(input logic [SIZE_W-1:0] s);
    return 32'(s) / 8;
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a,
                                                  input int unsigned b);
    return ADDR_W'((32'(a) + b) % MEM_BYTES);
  endfunction

  logic [7:0] mem_q [MEM_BYTES];

  state_t              state_q [N_CH];
  state_t              state_d [N_CH];
  logic [CNT_W-1:0]    cnt_q   [N_CH];
  logic [CNT_W-1:0]    cnt_d   [N_CH];
  logic [ADDR_W-1:0]   addr_q  [N_CH];
  logic [ADDR_W-1:0]   addr_d  [N_CH];
  logic [DATA_W-1:0]   wdata_q [N_CH];
  logic [DATA_W-1:0]   wdata_d [N_CH];
  logic [SIZE_W-1:0]   size_q  [N_CH];
  logic [SIZE_W-1:0]   size_d  [N_CH];
  logic                is_wr_q [N_CH];
  logic                is_wr_d [N_CH];
  logic                bad_q   [N_CH];
  logic                bad_d   [N_CH];

  logic                bad_now [N_CH];
  logic                samp    [N_CH];
  logic                wr_go   [N_CH];
  logic [ADDR_W-1:0]   wr_addr [N_CH];
  logic [DATA_W-1:0]   wr_data [N_CH];
  logic [SIZE_W-1:0]   wr_size [N_CH];
  logic                wr_bad  [N_CH];

  logic                wbe [N_CH][NB];
  logic [ADDR_W-1:0]   wba [N_CH][NB];
  logic [7:0]          wbd [N_CH][NB];

`ifdef BAMBU_MEM_RESP_ERR_CHECK_EN
  logic sz_bad  [N_CH];
  logic both_hi [N_CH];
  logic rng_bad [N_CH];
  logic err_q;

  // Classify each channel's incoming request for protocol errors.
  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      sz_bad[c]  = (M_data_ram_size[c*SIZE_W +: 3] != 3'd0) ||
                   (M_data_ram_size[c*SIZE_W +: SIZE_W] == '0) ||
                   (32'(M_data_ram_size[c*SIZE_W +: SIZE_W]) > DATA_W);
      both_hi[c] = M_oe_ram[c] && M_we_ram[c];
      rng_bad[c] = (32'(M_addr_ram[c*ADDR_W +: ADDR_W]) +
                    nbytes(M_data_ram_size[c*SIZE_W +: SIZE_W])) > MEM_BYTES;
      bad_now[c] = sz_bad[c] || both_hi[c] || rng_bad[c];
    end
  end

  // Sticky error flag, set by any faulty request sampled in IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (samp[c] && bad_now[c]) begin
          err_q <= 1'b1;
`ifndef SYNTHESIS
          $display("bambu_ext_mem_responder: ch%0d protocol error size=%0b oe_we=%0b range=%0b",
                   c, sz_bad[c], both_hi[c], rng_bad[c]);
`endif
        end
      end
    end
  end

  assign err = err_q;
`else
  // Without checking, no request is ever flagged.
  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      bad_now[c] = 1'b0;
    end
  end

  assign err = 1'b0;
`endif

  // Per-channel next-state logic and the write commit taken on entry to RESP.
  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      addr_d[c]  = addr_q[c];
      wdata_d[c] = wdata_q[c];
      size_d[c]  = size_q[c];
      is_wr_d[c] = is_wr_q[c];
      bad_d[c]   = bad_q[c];
      samp[c]    = 1'b0;
      wr_go[c]   = 1'b0;
      wr_addr[c] = addr_q[c];
      wr_data[c] = wdata_q[c];
      wr_size[c] = size_q[c];
      wr_bad[c]  = bad_q[c];
      unique case (state_q[c])
        S_IDLE: begin
          if (M_we_ram[c] || M_oe_ram[c]) begin
            samp[c]    = 1'b1;
            addr_d[c]  = M_addr_ram[c*ADDR_W +: ADDR_W];
            wdata_d[c] = M_Wdata_ram[c*DATA_W +: DATA_W];
            size_d[c]  = M_data_ram_size[c*SIZE_W +: SIZE_W];
            is_wr_d[c] = M_we_ram[c];
            bad_d[c]   = bad_now[c];
            if (M_we_ram[c]) begin
              // A one-cycle write commits at the sample edge itself,
              // so the live request fields feed the memory directly.
              if (WRITE_DELAY == 1) begin
                state_d[c] = S_RESP;
                wr_go[c]   = 1'b1;
                wr_addr[c] = M_addr_ram[c*ADDR_W +: ADDR_W];
                wr_data[c] = M_Wdata_ram[c*DATA_W +: DATA_W];
                wr_size[c] = M_data_ram_size[c*SIZE_W +: SIZE_W];
                wr_bad[c]  = bad_now[c];
              end else begin
                state_d[c] = S_WR_WAIT;
                cnt_d[c]   = CNT_W'(WRITE_DELAY - 1);
              end
            end else begin
              if (READ_DELAY == 1) begin
                state_d[c] = S_RESP;
              end else begin
                state_d[c] = S_RD_WAIT;
                cnt_d[c]   = CNT_W'(READ_DELAY - 1);
              end
            end
          end
        end
        S_RD_WAIT, S_WR_WAIT: begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
          if (cnt_q[c] == CNT_W'(1)) begin
            state_d[c] = S_RESP;
            wr_go[c]   = (state_q[c] == S_WR_WAIT);
          end
        end
        S_RESP: begin
          state_d[c] = S_IDLE;
        end
        default: begin
          state_d[c] = S_IDLE;
        end
      endcase
    end
  end

  // Expand each committing write into per-byte enables, addresses and data.
  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      for (int unsigned b = 0; b < NB; b++) begin
        wbe[c][b] = wr_go[c] && !wr_bad[c] && !reset && (b < nbytes(wr_size[c]));
        wba[c][b] = wrap_addr(wr_addr[c], b);
        wbd[c][b] = wr_data[c][8*b +: 8];
      end
    end
  end

  // Channel state registers; reset drops any in-flight access.
  always_ff @(posedge clock) begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (reset) begin
        state_q[c] <= S_IDLE;
        cnt_q[c]   <= '0;
        addr_q[c]  <= '0;
        wdata_q[c] <= '0;
        size_q[c]  <= '0;
        is_wr_q[c] <= 1'b0;
        bad_q[c]   <= 1'b0;
      end else begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        addr_q[c]  <= addr_d[c];
        wdata_q[c] <= wdata_d[c];
        size_q[c]  <= size_d[c];
        is_wr_q[c] <= is_wr_d[c];
        bad_q[c]   <= bad_d[c];
      end
    end
  end

  // Memory array (never reset); later assignments win, so channel writes
  // override the preload port and higher channels override lower ones.
  always_ff @(posedge clock) begin
    if (pl_we) begin
      mem_q[pl_addr] <= pl_wdata;
    end
    for (int unsigned c = 0; c < N_CH; c++) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wbe[c][b]) begin
          mem_q[wba[c][b]] <= wbd[c][b];
        end
      end
    end
  end

  // Response outputs: strobe in RESP, read data zero-extended, else zero.
  always_comb begin
    M_DataRdy   = '0;
    M_Rdata_ram = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      M_DataRdy[c] = (state_q[c] == S_RESP);
      if ((state_q[c] == S_RESP) && !is_wr_q[c] && !bad_q[c]) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (b < nbytes(size_q[c])) begin
            M_Rdata_ram[c*DATA_W + 8*b +: 8] = mem_q[wrap_addr(addr_q[c], b)];
          end
        end
      end
    end
  end

  assign pl_rdata = mem_q[pl_addr];

endmodule

// File: tb/tb_bambu_ext_mem_responder.sv
// Directed self-checking bench for bambu_ext_mem_responder (default
// parameters), plus a second instance with a three-cycle write latency
// used for the latency and reset-abort scenarios.
module tb_bambu_ext_mem_responder;

  logic        clock;
  logic        reset;
  logic [1:0]  M_oe_ram, M_we_ram;
  logic [13:0] M_addr_ram;
  logic [31:0] M_Wdata_ram;
  logic [9:0]  M_data_ram_size;
  logic [31:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;
  logic        pl_we;
  logic [6:0]  pl_addr;
  logic [7:0]  pl_wdata, pl_rdata;
  logic        err;

  logic        b_reset;
  logic [1:0]  b_oe, b_we;
  logic [13:0] b_addr;
  logic [31:0] b_wdata;
  logic [9:0]  b_size;
  logic [31:0] b_rdata;
  logic [1:0]  b_rdy;
  logic        b_pl_we;
  logic [6:0]  b_pl_addr;
  logic [7:0]  b_pl_wdata, b_pl_rdata;
  logic        b_err;

  int errors = 0;
  int checks = 0;

  bambu_ext_mem_responder dut (
    .clock(clock), .reset(reset),
    .M_oe_ram(M_oe_ram), .M_we_ram(M_we_ram), .M_addr_ram(M_addr_ram),
    .M_Wdata_ram(M_Wdata_ram), .M_data_ram_size(M_data_ram_size),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
    .pl_we(pl_we), .pl_addr(pl_addr), .pl_wdata(pl_wdata), .pl_rdata(pl_rdata),
    .err(err)
  );

  bambu_ext_mem_responder #(.WRITE_DELAY(3)) dut3 (
    .clock(clock), .reset(b_reset),
    .M_oe_ram(b_oe), .M_we_ram(b_we), .M_addr_ram(b_addr),
    .M_Wdata_ram(b_wdata), .M_data_ram_size(b_size),
    .M_Rdata_ram(b_rdata), .M_DataRdy(b_rdy),
    .pl_we(b_pl_we), .pl_addr(b_pl_addr), .pl_wdata(b_pl_wdata), .pl_rdata(b_pl_rdata),
    .err(b_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_wdata = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; b_reset = 1'b1;
    tick(); tick();
    reset = 1'b0; b_reset = 1'b0;
    tick();
    checks++;
    if (M_DataRdy !== 2'b00) begin errors++; $display("FAIL reset_rdy: got %b expected 00", M_DataRdy); end
    checks++;
    if (M_Rdata_ram !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", M_Rdata_ram); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++;
    if (b_rdy !== 2'b00) begin errors++; $display("FAIL reset_rdy_d3: got %b expected 00", b_rdy); end
  endtask

  task automatic test_read_latency();
    preload(7'h10, 8'h34);
    preload(7'h11, 8'h12);
    M_oe_ram[0] = 1'b1; M_addr_ram[6:0] = 7'h10; M_data_ram_size[4:0] = 5'd16;
    tick();  // T+1
    M_oe_ram[0] = 1'b0;
    checks++;
    if (M_DataRdy !== 2'b00) begin errors++; $display("FAIL rd_rdy_t1: got %b expected 00", M_DataRdy); end
    checks++;
    if (M_Rdata_ram[15:0] !== 16'h0000) begin errors++; $display("FAIL rd_data_t1: got %h expected 0000", M_Rdata_ram[15:0]); end
    tick();  // T+2
    checks++;
    if (M_DataRdy !== 2'b01) begin errors++; $display("FAIL rd_rdy_t2: got %b expected 01", M_DataRdy); end
    checks++;
    if (M_Rdata_ram[15:0] !== 16'h1234) begin errors++; $display("FAIL rd_data_t2: got %h expected 1234", M_Rdata_ram[15:0]); end
    tick();  // T+3
    checks++;
    if (M_DataRdy !== 2'b00) begin errors++; $display("FAIL rd_rdy_t3: got %b expected 00", M_DataRdy); end
    checks++;
    if (M_Rdata_ram[15:0] !== 16'h0000) begin errors++; $display("FAIL rd_data_t3: got %h expected 0000", M_Rdata_ram[15:0]); end
  endtask

  task automatic test_write();
    preload(7'h20, 8'h00);
    preload(7'h21, 8'h5A);
    M_we_ram[1] = 1'b1; M_addr_ram[13:7] = 7'h20; M_data_ram_size[9:5] = 5'd8;
    M_Wdata_ram[31:16] = 16'hABCD;
    tick();  // T+1
    M_we_ram[1] = 1'b0;
    checks++;
    if (M_DataRdy !== 2'b10) begin errors++; $display("FAIL wr_rdy_t1: got %b expected 10", M_DataRdy); end
    pl_addr = 7'h20; #1;
    checks++;
    if (pl_rdata !== 8'hCD) begin errors++; $display("FAIL wr_byte20: got %h expected cd", pl_rdata); end
    pl_addr = 7'h21; #1;
    checks++;
    if (pl_rdata !== 8'h5A) begin errors++; $display("FAIL wr_byte21: got %h expected 5a", pl_rdata); end
    tick();  // T+2
    checks++;
    if (M_DataRdy !== 2'b00) begin errors++; $display("FAIL wr_rdy_t2: got %b expected 00", M_DataRdy); end
  endtask

  task automatic test_write_conflict();
    M_we_ram = 2'b11;
    M_addr_ram = {7'h05, 7'h05};
    M_data_ram_size = {5'd8, 5'd8};
    M_Wdata_ram = {16'h0022, 16'h0011};
    tick();
    M_we_ram = 2'b00;
    tick();  // channels back in IDLE
    M_we_ram[0] = 1'b1; M_addr_ram[6:0] = 7'h06; M_Wdata_ram[15:0] = 16'h0099;
    pl_we = 1'b1; pl_addr = 7'h06; pl_wdata = 8'h77;
    tick();
    M_we_ram[0] = 1'b0; pl_we = 1'b0;
    pl_addr = 7'h05; #1;
    checks++;
    if (pl_rdata !== 8'h22) begin errors++; $display("FAIL ww_conflict: got %h expected 22", pl_rdata); end
    pl_addr = 7'h06; #1;
    checks++;
    if (pl_rdata !== 8'h99) begin errors++; $display("FAIL pl_vs_ch: got %h expected 99", pl_rdata); end
    tick();
  endtask

  task automatic test_hold_oe();
    logic exp_rdy;
    preload(7'h00, 8'h3C);
    preload(7'h01, 8'hFF);
    M_oe_ram[0] = 1'b1; M_addr_ram[6:0] = 7'h00; M_data_ram_size[4:0] = 5'd8;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 6) M_oe_ram[0] = 1'b0;
      exp_rdy = (i == 2) || (i == 5);
      checks++;
      if (M_DataRdy[0] !== exp_rdy) begin
        errors++; $display("FAIL hold_rdy_t%0d: got %b expected %b", i, M_DataRdy[0], exp_rdy);
      end
      if (exp_rdy) begin
        checks++;
        if (M_Rdata_ram[15:0] !== 16'h003C) begin
          errors++; $display("FAIL hold_data_t%0d: got %h expected 003c", i, M_Rdata_ram[15:0]);
        end
      end
    end
    tick();
  endtask

  task automatic test_delay3_and_reset();
    b_pl_we = 1'b1; b_pl_addr = 7'h30; b_pl_wdata = 8'h55;
    tick();
    b_pl_we = 1'b0;
    // normal three-cycle write
    b_we[0] = 1'b1; b_addr[6:0] = 7'h31; b_size[4:0] = 5'd8; b_wdata[15:0] = 16'h0066;
    for (int i = 1; i <= 3; i++) begin
      tick();
      b_we[0] = 1'b0;
      checks++;
      if (b_rdy[0] !== (i == 3)) begin
        errors++; $display("FAIL d3_rdy_t%0d: got %b expected %b", i, b_rdy[0], (i == 3));
      end
    end
    b_pl_addr = 7'h31; #1;
    checks++;
    if (b_pl_rdata !== 8'h66) begin errors++; $display("FAIL d3_byte31: got %h expected 66", b_pl_rdata); end
    tick();
    // write aborted by reset one cycle after the request
    b_we[0] = 1'b1; b_addr[6:0] = 7'h30; b_wdata[15:0] = 16'h00AA;
    tick();
    b_we[0] = 1'b0; b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (b_rdy !== 2'b00) begin errors++; $display("FAIL abort_rdy_%0d: got %b expected 00", i, b_rdy); end
      tick();
    end
    b_pl_addr = 7'h30; #1;
    checks++;
    if (b_pl_rdata !== 8'h55) begin errors++; $display("FAIL abort_mem: got %h expected 55", b_pl_rdata); end
    checks++;
    if (b_err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b expected 0", b_err); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] exp_data;
    logic        exp_err;
`ifdef BAMBU_MEM_RESP_ERR_CHECK_EN
    exp_data = 16'h0000; exp_err = 1'b1;
`else
    exp_data = 16'h3CE1; exp_err = 1'b0;
`endif
    preload(7'h7F, 8'hE1);
    preload(7'h00, 8'h3C);
    M_oe_ram[0] = 1'b1; M_addr_ram[6:0] = 7'h7F; M_data_ram_size[4:0] = 5'd16;
    tick();  // T+1
    M_oe_ram[0] = 1'b0;
    checks++;
    if (M_DataRdy[0] !== 1'b0) begin errors++; $display("FAIL oor_rdy_t1: got %b expected 0", M_DataRdy[0]); end
    tick();  // T+2
    checks++;
    if (M_DataRdy[0] !== 1'b1) begin errors++; $display("FAIL oor_rdy_t2: got %b expected 1", M_DataRdy[0]); end
    checks++;
    if (M_Rdata_ram[15:0] !== exp_data) begin errors++; $display("FAIL oor_data: got %h expected %h", M_Rdata_ram[15:0], exp_data); end
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL oor_err: got %b expected %b", err, exp_err); end
    tick(); tick(); tick();
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL oor_err_sticky: got %b expected %b", err, exp_err); end
  endtask

  initial begin
    reset = 1'b1; b_reset = 1'b1;
    M_oe_ram = '0; M_we_ram = '0; M_addr_ram = '0; M_Wdata_ram = '0; M_data_ram_size = '0;
    pl_we = 1'b0; pl_addr = '0; pl_wdata = '0;
    b_oe = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_size = '0;
    b_pl_we = 1'b0; b_pl_addr = '0; b_pl_wdata = '0;
    test_reset();
    test_read_latency();
    test_write();
    test_write_conflict();
    test_hold_oe();
    test_delay3_and_reset();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bambu_ext_mem_responder.md
Name: bambu_ext_mem_responder

Overview:
- Behavioural/synthesizable memory responder for the master-side RAM interface of a Bambu-generated top (`main`).
- Answers M_oe_ram/M_we_ram requests on every channel with fixed read/write latencies.
- Testbenches instantiate it next to the accelerator in place of an external memory. A bench-side preload/peek port initialises and inspects contents.
- Synthesizable so the same block can back on-FPGA smoke tests.

Parameters:
- N_CH, 2, number of independent request channels
- ADDR_W, 7, byte-address width per channel
- DATA_W, 16, data width per channel; multiple of 8
- SIZE_W, 5, access-size field width per channel; value is in bits
- MEM_BYTES, 128, memory depth in bytes; at most 2**ADDR_W
- READ_DELAY, 2, cycles from request sample to M_DataRdy for reads; at least 1
- WRITE_DELAY, 1, cycles from request sample to M_DataRdy for writes; at least 1

Ports:
- clock  in  1  single clock, posedge
- reset  in  1  synchronous, active-high
- M_oe_ram  in  N_CH  per-channel read request
- M_we_ram  in  N_CH  per-channel write request
- M_addr_ram  in  N_CH*ADDR_W  packed byte addresses, channel i at [i*ADDR_W +: ADDR_W]
- M_Wdata_ram  in  N_CH*DATA_W  packed write data
- M_data_ram_size  in  N_CH*SIZE_W  packed access size in bits (8..DATA_W, multiple of 8)
- M_Rdata_ram  out  N_CH*DATA_W  packed read data
- M_DataRdy  out  N_CH  per-channel completion strobe
- pl_we  in  1  bench preload byte write
- pl_addr  in  ADDR_W  preload/peek byte address
- pl_wdata  in  8  preload byte
- pl_rdata  out  8  combinational peek of mem[pl_addr]
- err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Storage: MEM_BYTES bytes, little-endian. An access of size S at address A covers bytes A..A+S/8-1.
- Reset: all channels go to IDLE; M_DataRdy=0, M_Rdata_ram=0, err=0. Memory contents are NOT cleared, including on reset mid-operation. Any in-flight access is dropped with no write performed.
- Per-channel FSM: IDLE -> RD_WAIT or WR_WAIT -> RESP -> IDLE.
- IDLE, sampling at posedge:
  - we=1 goes to WR_WAIT; we has priority over oe when both are high.
  - oe=1 (with we=0) goes to RD_WAIT.
  - On either, latch addr, wdata and size; load the counter with DELAY-1.
- WAIT: decrement the counter. At 0, go to RESP, so M_DataRdy is high exactly DELAY cycles after the sample edge.
  - Delay 1: DataRdy is high in the cycle right after the sample.
- RESP, lasting one cycle with M_DataRdy=1:
  - Read: M_Rdata_ram lane carries the memory bytes at that cycle, zero-extended above the size.
  - Write: the covered bytes are updated at the edge that enters RESP.
- M_Rdata_ram lane is 0 whenever its M_DataRdy is 0.
- Requests held or raised during WAIT or RESP are ignored. The next sample happens in IDLE, the cycle after RESP. A master holding oe through DataRdy therefore gets exactly one response per request-then-release.
- Write/write conflict on the same byte at the same edge: the higher channel index wins.
- Preload write vs channel write to the same byte at the same edge: the channel write wins.
- Read RESP sees writes completed at earlier edges only; no same-cycle bypass.
- Out-of-range bytes (address >= MEM_BYTES): handling depends on the Optional Feature.

Optional Feature:
- Macro: BAMBU_MEM_RESP_ERR_CHECK_EN.
- Defined:
  - err goes and stays 1 on any of: size not a multiple of 8, 0, or > DATA_W; oe and we high together in IDLE; any covered byte >= MEM_BYTES.
  - The offending write is suppressed. The offending read returns 0.
  - The handshake still completes with normal latency.
  - A $display line naming the channel and cause is emitted (non-synthesis only).
- Undefined: err is tied 0, and byte addresses wrap modulo MEM_BYTES.

Test Plan:
- Preload 0x34 @0x10 and 0x12 @0x11; ch0 oe=1, size=16, addr=0x10 at cycle T -> M_DataRdy[0]=1 only in cycle T+2; Rdata lane0=0x1234; lane0=0 at T+1 and T+3.
- ch1 we=1, addr=0x20, size=8, wdata=0xABCD at T -> DataRdy[1] at T+1; pl_rdata@0x20=0xCD and @0x21 unchanged.
- ch0 and ch1 both write size=8 to 0x05 completing at the same edge, data 0x11 and 0x22 -> mem[0x05]=0x22.
- ch0 holds oe=1 for 6 cycles, addr 0x00 -> exactly one DataRdy pulse (T+2), then a second at T+5 from the re-sample in IDLE at T+3.
- Assert reset one cycle after a write request with WRITE_DELAY=1 overridden to 3 -> no DataRdy, memory byte unchanged, err=0.
- With BAMBU_MEM_RESP_ERR_CHECK_EN: size=16 read at addr 0x7F -> DataRdy at T+2, Rdata=0, err=1 and sticky. Without the macro: the same read returns {mem[0x00],mem[0x7F]}.
